// File: rtl/idct_dequant_unzigzag.sv
// idct_dequant_unzigzag: dequantizes a zigzag-ordered JPEG coefficient stream into a ping-pong 8x8 buffer and replays it in raster order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast  quantized coefficients in zigzag order, tlast ends a block early
//   m_tdata/m_tvalid/m_tready/m_tlast  dequantized coefficients in raster order, tlast on raster index 63
//   blk_err               one-cycle pulse after a 64th beat that arrived without s_tlast
module idct_dequant_unzigzag #(
   parameter int COEFF_WIDTH = 12,
   parameter int OUT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COEFF_WIDTH-1:0] s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   output logic [OUT_WIDTH-1:0]   m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic                   blk_err
);
   localparam int PW = COEFF_WIDTH + 8;
   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
   localparam int Q [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99};
   localparam logic signed [PW-1:0] PMAX = PW'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [PW-1:0] PMIN = ~PMAX;

   logic [OUT_WIDTH-1:0] mem [2][64];
   logic [63:0] mask [2];
   logic [1:0] full;
   logic wb, rb;
   logic [5:0] k, r;
   logic [5:0] nat;
   logic [7:0] q;
   logic signed [PW-1:0] prod;
   logic [OUT_WIDTH-1:0] sat;
   logic hs, close, ld, rd, rel;

   assign s_tready = !full[wb];
   assign hs = s_tvalid && s_tready;
   assign close = hs && (s_tlast || &k);
   assign nat = 6'(ZZ[k]);
   assign q = 8'(Q[nat]);
   assign prod = PW'($signed(s_tdata)) * $signed(PW'(q));
   assign sat = prod > PMAX ? OUT_WIDTH'(PMAX) : prod < PMIN ? OUT_WIDTH'(PMIN) : prod[OUT_WIDTH-1:0];
   assign ld = !m_tvalid || m_tready;
   assign rd = ld && full[rb];
   assign rel = rd && &r;

   always_ff @(posedge clk)
      if (hs) mem[wb][nat] <= sat;

   // The mask of a bank is cleared when the reader releases it, so the bank is
   // already clean when the writer next enters it, and a bank still being
   // replayed is never wiped by the writer closing the other one.
   // A close needs !full[wb] and a release needs full[rb], so in any cycle with
   // both events wb != rb and the per-bank updates below never collide.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wb <= 1'b0;
         rb <= 1'b0;
         k <= '0;
         r <= '0;
         full <= '0;
         mask <= '{default: '0};
         m_tvalid <= 1'b0;
         m_tlast <= 1'b0;
         m_tdata <= '0;
         blk_err <= 1'b0;
      end else begin
         blk_err <= hs && &k && !s_tlast;
         if (hs) begin
            mask[wb][nat] <= 1'b1;
            k <= close ? 6'd0 : k + 6'd1;
         end
         if (close) begin
            full[wb] <= 1'b1;
            wb <= !wb;
         end
         if (rel) begin
            full[rb] <= 1'b0;
            mask[rb] <= '0;
            rb <= !rb;
         end
         if (ld) m_tvalid <= full[rb];
         if (rd) begin
            m_tdata <= mask[rb][r] ? mem[rb][r] : '0;
            m_tlast <= &r;
            r <= r + 6'd1;
         end
      end
endmodule

// File: tb/tb_idct_dequant_unzigzag.sv
// tb_idct_dequant_unzigzag: random and directed stimulus against a block-level model of dequantize plus zigzag reorder.
module tb_idct_dequant_unzigzag;
   localparam int CW = 12;
   localparam int OW = 16;
   localparam int Q [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [CW-1:0] s_tdata = '0;
   logic s_tvalid = 1'b0;
   logic s_tlast = 1'b0;
   logic s_tready;
   logic [OW-1:0] m_tdata;
   logic m_tvalid, m_tlast, blk_err;
   logic m_tready = 1'b0;
   bit rand_rdy = 1'b0;
   bit rdy_force = 1'b0;
   int n_vec = 0;
   int n_err = 0;
   int zz [64];
   int vals [64];
   int exp_d [$];
   bit exp_l [$];
   bit prev_v, prev_r;
   int prev_d;

   idct_dequant_unzigzag #(.COEFF_WIDTH(CW), .OUT_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .blk_err(blk_err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   function automatic int sat(input int p);
      return p > 32767 ? 32767 : p < -32768 ? -32768 : p;
   endfunction

   // Expected raster block: every position not written by the first n zigzag beats is zero.
   task automatic push_block(input int n);
      int e [64];
      for (int j = 0; j < 64; j++) e[j] = 0;
      for (int i = 0; i < n; i++) e[zz[i]] = sat(vals[i] * Q[zz[i]]);
      for (int j = 0; j < 64; j++) begin
         exp_d.push_back(e[j]);
         exp_l.push_back(j == 63);
      end
   endtask

   task automatic send(input int n, input bit last);
      int g;
      for (int i = 0; i < n; i++) begin
         s_tdata = CW'(vals[i]);
         s_tvalid = 1'b1;
         s_tlast = last && i == n - 1;
         g = 0;
         @(negedge clk);
         while (!s_tready && g < 2000) begin
            @(negedge clk);
            g++;
         end
         if (!s_tready) begin
            check("s_tready_wait", s_tready, 1);
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (i == n - 1 && (last || n == 64)) push_block(n);
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      if (last || n == 64) check("blk_err", blk_err, int'(n == 64 && !last));
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_d.size() != 0 && g < 3000) begin
         @(posedge clk);
         g++;
      end
      repeat (5) @(posedge clk);
      #1;
      check("drain", exp_d.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   always @(negedge clk) begin
      if (!rst_n) prev_v = 1'b0;
      else begin
         if (prev_v && !prev_r) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", int'($signed(m_tdata)), prev_d);
         end
         if (m_tvalid && m_tready) begin
            if (exp_d.size() == 0) check("extra_beat", m_tvalid, 0);
            else begin
               check("m_tdata", int'($signed(m_tdata)), exp_d.pop_front());
               check("m_tlast", m_tlast, exp_l.pop_front());
            end
         end
         prev_v = m_tvalid;
         prev_r = m_tready;
         prev_d = int'($signed(m_tdata));
      end
   end

   initial begin
      int idx = 0;
      int row, col;
      for (int s = 0; s < 15; s++)
         for (int j = 0; j <= s; j++) begin
            row = (s % 2 == 0) ? s - j : j;
            col = s - row;
            if (row < 8 && col < 8) begin
               zz[idx] = row * 8 + col;
               idx++;
            end
         end
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_tready_low", s_tready, 1);
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", int'(m_tdata), 0);
      check("rst_blk_err", blk_err, 0);
      check("rst_s_tready", s_tready, 1);
      @(posedge clk);
      #1;
      // DC only, with latency
      vals[0] = 5;
      send(1, 1'b1);
      check("lat_t1", m_tvalid, 0);
      @(posedge clk);
      #1;
      check("lat_t2", m_tvalid, 1);
      check("dc_first", int'($signed(m_tdata)), 80);
      wait_drain();
      // Table replay
      for (int i = 0; i < 64; i++) vals[i] = 1;
      send(64, 1'b1);
      wait_drain();
      // Zigzag map
      for (int i = 0; i < 64; i++) vals[i] = 0;
      vals[2] = 1;
      send(3, 1'b1);
      vals[2] = 0;
      vals[5] = 1;
      send(6, 1'b1);
      wait_drain();
      // Saturation
      for (int i = 0; i < 64; i++) vals[i] = 0;
      vals[63] = 2047;
      send(64, 1'b1);
      vals[63] = -2048;
      send(64, 1'b1);
      wait_drain();
      // Backpressure
      rdy_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vals[0] = 1;
      send(1, 1'b1);
      vals[0] = 2;
      send(1, 1'b1);
      check("bp_s_tready", s_tready, 0);
      vals[0] = 3;
      fork
         send(1, 1'b1);
         begin
            repeat (20) @(posedge clk);
            #1;
            check("bp_stall", s_tready, 0);
            check("bp_hold", int'($signed(m_tdata)), 16);
            rdy_force = 1'b1;
         end
      join
      wait_drain();
      // Missing tlast
      for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 40)) - 20;
      send(64, 1'b0);
      @(posedge clk);
      #1;
      check("blk_err_end", blk_err, 0);
      vals[0] = 7;
      send(1, 1'b1);
      wait_drain();
      // Reset mid-block
      for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 40)) - 20;
      send(30, 1'b0);
      rst_n = 1'b0;
      #3;
      check("mid_rst_s_tready", s_tready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check("mid_rst_no_out", m_tvalid, 0);
      check("mid_rst_s_tready2", s_tready, 1);
      vals[0] = 9;
      vals[1] = -4;
      send(2, 1'b1);
      wait_drain();
      // Random blocks with random downstream stalls
      rand_rdy = 1'b1;
      for (int b = 0; b < 40; b++) begin
         int n;
         bit last;
         n = int'($urandom_range(1, 64));
         last = n < 64 ? 1'b1 : bit'($urandom_range(0, 1));
         for (int i = 0; i < 64; i++)
            vals[i] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4095)) - 2048
                                                 : int'($urandom_range(0, 40)) - 20;
         send(n, last);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_drain();
      rand_rdy = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
